cpu_stack: RTL and testbench
============================

Name: cpu_stack

Overview:
- Parameterised LIFO that sits directly downstream of the cpu core. The cpu drives push/pop/data_in; this block returns top-of-stack and full/empty status.
- Two instances are used in the system, one for the operand stack and one for the subroutine return stack. Port semantics match the cpu stack_* ports.
- Single-cycle push, pop and replace-top operations.
- Registered top-of-stack output.
- Overflow and underflow detection.

Parameters:
- WIDTH_DATA, 16, width of each stack entry in bits.
- DEPTH_LOG2, 4, log2 of stack depth. DEPTH = 2**DEPTH_LOG2 entries.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- push  input  1  push request, sampled on rising clk.
- pop  input  1  pop request, sampled on rising clk.
- data_in  input  WIDTH_DATA  value to push.
- data_out  output  WIDTH_DATA  registered top-of-stack.
- full  output  1  high when count == DEPTH.
- empty  output  1  high when count == 0.
- count  output  DEPTH_LOG2+1  number of valid entries, 0..DEPTH.
- overflow  output  1  error flag: push rejected because stack full.
- underflow  output  1  error flag: pop rejected because stack empty.
- clear_err  input  1  present only when CPU_STACK_ERR_STICKY_EN is defined.

Behaviour:
- Storage: DEPTH x WIDTH_DATA register array mem[0..DEPTH-1]. Stack pointer sp = count; sp points to the next free slot.
- full and empty are combinational decodes of sp.
- Reset (reset low, asynchronous assert):
  - sp=0, data_out=0, overflow=0, underflow=0.
  - mem contents are not reset and are don't-care.
  - Reset asserted mid-operation discards any in-flight request. The stack is empty on the first edge after release.
- Latency: all operations complete on the same rising edge. data_out, count, full and empty reflect the new state immediately after that edge.
- Per edge (reset high), priority by case:
  - Idle (push=0, pop=0): no change.
  - Push only, not full: mem[sp]<=data_in; sp<=sp+1; data_out<=data_in.
  - Push only, full: state unchanged; overflow asserted.
  - Pop only, sp>=2: sp<=sp-1; data_out<=mem[sp-2].
  - Pop only, sp==1: sp<=0; data_out<=0.
  - Pop only, empty: state unchanged; underflow asserted.
  - Push and pop, not empty (including full): replace top. mem[sp-1]<=data_in; data_out<=data_in; sp unchanged; no error.
  - Push and pop, empty: behaves as push only (sp<=1, data_out<=data_in); no error.
- Error flags (default build): overflow and underflow are single-cycle pulses, high for exactly the one cycle following the offending edge, low otherwise.
- Invariants:
  - data_out always equals mem[sp-1] when sp>0, and 0 when sp==0.
  - sp never wraps; it is saturated at 0 and DEPTH by the rejection rules.
  - No combinational path from push/pop/data_in to any output.

Optional Feature:
- Macro: CPU_STACK_ERR_STICKY_EN.
- Defined:
  - Port clear_err exists.
  - overflow and underflow are sticky: once set, they remain high until a rising edge with clear_err=1.
  - clear_err clears both flags on that edge, unless a new error occurs on the same edge, in which case the new error's flag is set (set wins).
  - Reset clears both flags.
- Undefined: clear_err port absent; flags behave as one-cycle pulses.

Test Plan:
- Reset then idle (DEPTH_LOG2=2) -> data_out=0, count=0, empty=1, full=0, overflow=0, underflow=0.
- Push 0x0005, then push 0x0002 -> after edge 1: data_out=0x0005, count=1. After edge 2: data_out=0x0002, count=2.
- Continue pushing 0x0003, 0x0004 (count=4, full=1), then push 0x00FF -> state unchanged, data_out=0x0004, overflow pulses one cycle.
- Pop x4 from that state -> data_out sequence 0x0003, 0x0002, 0x0005, 0x0000; empty=1. A fifth pop -> underflow pulses, count stays 0.
- Push 0x0011, then push+pop with data_in=0x0022 -> count=1, data_out=0x0022. Push+pop on empty stack with data_in=0x0033 -> count=1, data_out=0x0033, no error.
- Three pushes, then reset low mid-cycle -> outputs go to reset values asynchronously, count=0. With CPU_STACK_ERR_STICKY_EN: pop on empty -> underflow held for 5+ cycles until clear_err=1 edge, then 0.

Source files
------------

// File: rtl/cpu_stack.sv
// cpu_stack: parameterised LIFO with registered top-of-stack and full/empty/error status.
// Optional build macro CPU_STACK_ERR_STICKY_EN adds clear_err and makes the error flags sticky.
module cpu_stack #(
  parameter int WIDTH_DATA = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef CPU_STACK_ERR_STICKY_EN
  input  logic                  clear_err,
`endif
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH_DATA-1:0] data_in,
  output logic [WIDTH_DATA-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  typedef logic [DEPTH_LOG2:0]   ptr_t;
  typedef logic [DEPTH_LOG2-1:0] addr_t;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_POP_LAST,
    OP_REPLACE,
    OP_REJECT_PUSH,
    OP_REJECT_POP
  } op_e;

  logic [WIDTH_DATA-1:0] mem [DEPTH];
  ptr_t                  sp;
  op_e                   op;

  ptr_t                  sp_nxt;
  logic [WIDTH_DATA-1:0] data_out_nxt;
  logic                  wr_en;
  addr_t                 wr_addr;
  logic                  ovf_evt;
  logic                  udf_evt;
  logic                  overflow_nxt;
  logic                  underflow_nxt;

  assign count = sp;
  assign full  = (sp == ptr_t'(DEPTH));
  assign empty = (sp == '0);

  // Push+pop on an empty stack degenerates to a plain push.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    op = OP_IDLE;
    case ({push, pop})
      2'b10:   op = full ? OP_REJECT_PUSH : OP_PUSH;
      2'b01: begin
        if (empty)                op = OP_REJECT_POP;
        else if (sp == ptr_t'(1)) op = OP_POP_LAST;
        else                      op = OP_POP;
      end
      2'b11:   op = empty ? OP_PUSH : OP_REPLACE;
      default: op = OP_IDLE;
    endcase
  end

  always_comb begin
    sp_nxt       = sp;
    data_out_nxt = data_out;
    wr_en        = 1'b0;
    wr_addr      = addr_t'(sp);
    ovf_evt      = 1'b0;
    udf_evt      = 1'b0;
    case (op)
      OP_PUSH: begin
        wr_en        = 1'b1;
        wr_addr      = addr_t'(sp);
        sp_nxt       = sp + ptr_t'(1);
        data_out_nxt = data_in;
      end
      OP_POP: begin
        sp_nxt       = sp - ptr_t'(1);
        data_out_nxt = mem[addr_t'(sp - ptr_t'(2))];
      end
      OP_POP_LAST: begin
        sp_nxt       = '0;
        data_out_nxt = '0;
      end
      OP_REPLACE: begin
        wr_en        = 1'b1;
        wr_addr      = addr_t'(sp - ptr_t'(1));
        data_out_nxt = data_in;
      end
      OP_REJECT_PUSH: ovf_evt = 1'b1;
      OP_REJECT_POP:  udf_evt = 1'b1;
      default: ;
    endcase
  end

`ifdef CPU_STACK_ERR_STICKY_EN
  // A new error on the clearing edge wins over clear_err.
  assign overflow_nxt  = ovf_evt | (overflow  & ~clear_err);
  assign underflow_nxt = udf_evt | (underflow & ~clear_err);
`else
  assign overflow_nxt  = ovf_evt;
  assign underflow_nxt = udf_evt;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp        <= '0;
      data_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      sp        <= sp_nxt;
      data_out  <= data_out_nxt;
      overflow  <= overflow_nxt;
      underflow <= underflow_nxt;
    end
  end

  // NOTE: the storage array has no reset; stale entries are never visible because data_out tracks sp.
  always_ff @(posedge clk) begin
    if (reset && wr_en) mem[wr_addr] <= data_in;
  end

endmodule

// File: tb/tb_cpu_stack.sv
// Self-checking bench for cpu_stack (DEPTH_LOG2=2): vector table driven through a scoreboard queue,
// plus hand sequences for asynchronous reset and the sticky-error build.
module tb_cpu_stack;

  localparam int W  = 16;
  localparam int DL = 2;
  localparam int SW = W + DL + 1 + 4;

  logic          clk = 1'b0;
  logic          reset;
`ifdef CPU_STACK_ERR_STICKY_EN
  logic          clear_err;
`endif
  logic          push;
  logic          pop;
  logic [W-1:0]  data_in;
  logic [W-1:0]  data_out;
  logic          full;
  logic          empty;
  logic [DL:0]   count;
  logic          overflow;
  logic          underflow;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic         push;
    logic         pop;
    logic [W-1:0] data;
    logic [W-1:0] exp_data;
    logic [DL:0]  exp_count;
    logic         exp_ovf;
    logic         exp_udf;
  } vec_t;

  vec_t            vecs[$];
  logic [SW-1:0]   sb_q[$];

  cpu_stack #(.WIDTH_DATA(W), .DEPTH_LOG2(DL)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef CPU_STACK_ERR_STICKY_EN
    .clear_err (clear_err),
`endif
    .push      (push),
    .pop       (pop),
    .data_in   (data_in),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

  function automatic logic [SW-1:0] snap();
    return {data_out, count, full, empty, overflow, underflow};
  endfunction

  function automatic logic [SW-1:0] expect_of(input logic [W-1:0] d, input logic [DL:0] c,
                                              input logic ovf, input logic udf);
    return {d, c, (c == 3'd4), (c == 3'd0), ovf, udf};
  endfunction

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got data=%h count=%0d full=%b empty=%b ovf=%b udf=%b, expected data=%h count=%0d full=%b empty=%b ovf=%b udf=%b",
               name, act[SW-1 -: W], act[DL+4:4], act[3], act[2], act[1], act[0],
               exp[SW-1 -: W], exp[DL+4:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic add(input logic p, input logic q, input logic [W-1:0] d,
                     input logic [W-1:0] ed, input logic [DL:0] ec,
                     input logic ov, input logic ud);
    vec_t v;
    v.push = p; v.pop = q; v.data = d;
    v.exp_data = ed; v.exp_count = ec; v.exp_ovf = ov; v.exp_udf = ud;
    vecs.push_back(v);
  endtask

  // Drive one edge's worth of stimulus, queue its expectation, compare just after the edge.
  task automatic apply(input vec_t v, input string name);
    push    = v.push;
    pop     = v.pop;
    data_in = v.data;
    sb_q.push_back(expect_of(v.exp_data, v.exp_count, v.exp_ovf, v.exp_udf));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL %s: scoreboard empty, got %h", name, snap());
    end else begin
      check(name, snap(), sb_q.pop_front());
    end
  endtask

  task automatic step(input logic p, input logic q, input logic [W-1:0] d,
                      input logic [W-1:0] ed, input logic [DL:0] ec,
                      input logic ov, input logic ud, input string name);
    vec_t v;
    v.push = p; v.pop = q; v.data = d;
    v.exp_data = ed; v.exp_count = ec; v.exp_ovf = ov; v.exp_udf = ud;
    apply(v, name);
  endtask

  initial begin
    reset   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    data_in = '0;
`ifdef CPU_STACK_ERR_STICKY_EN
    // Clearing every edge makes sticky flags look like pulses for the shared table.
    clear_err = 1'b1;
`endif

    //       push pop data     exp_data exp_cnt ovf udf
    add(0, 0, 16'h0000, 16'h0000, 3'd0, 0, 0);  // idle after reset
    add(1, 0, 16'h0005, 16'h0005, 3'd1, 0, 0);
    add(1, 0, 16'h0002, 16'h0002, 3'd2, 0, 0);
    add(1, 0, 16'h0003, 16'h0003, 3'd3, 0, 0);
    add(1, 0, 16'h0004, 16'h0004, 3'd4, 0, 0);  // full
    add(1, 0, 16'h00FF, 16'h0004, 3'd4, 1, 0);  // overflow
    add(0, 0, 16'h0000, 16'h0004, 3'd4, 0, 0);  // pulse ends
    add(0, 1, 16'h0000, 16'h0003, 3'd3, 0, 0);
    add(0, 1, 16'h0000, 16'h0002, 3'd2, 0, 0);
    add(0, 1, 16'h0000, 16'h0005, 3'd1, 0, 0);
    add(0, 1, 16'h0000, 16'h0000, 3'd0, 0, 0);
    add(0, 1, 16'h0000, 16'h0000, 3'd0, 0, 1);  // underflow
    add(0, 0, 16'h0000, 16'h0000, 3'd0, 0, 0);
    add(1, 0, 16'h0011, 16'h0011, 3'd1, 0, 0);
    add(1, 1, 16'h0022, 16'h0022, 3'd1, 0, 0);  // replace top
    add(0, 1, 16'h0000, 16'h0000, 3'd0, 0, 0);
    add(1, 1, 16'h0033, 16'h0033, 3'd1, 0, 0);  // push+pop on empty
    add(1, 0, 16'h0044, 16'h0044, 3'd2, 0, 0);
    add(0, 1, 16'h0000, 16'h0033, 3'd1, 0, 0);
    add(1, 0, 16'h0055, 16'h0055, 3'd2, 0, 0);
    add(1, 0, 16'h0066, 16'h0066, 3'd3, 0, 0);
    add(1, 0, 16'h0077, 16'h0077, 3'd4, 0, 0);
    add(1, 1, 16'h0088, 16'h0088, 3'd4, 0, 0);  // replace top while full
    add(0, 1, 16'h0000, 16'h0066, 3'd3, 0, 0);
    add(0, 1, 16'h0000, 16'h0055, 3'd2, 0, 0);
    add(0, 1, 16'h0000, 16'h0033, 3'd1, 0, 0);
    add(0, 1, 16'h0000, 16'h0000, 3'd0, 0, 0);

    #12;
    check("reset_state", snap(), expect_of(16'h0000, 3'd0, 1'b0, 1'b0));
    reset = 1'b1;

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a cycle with entries on the stack.
    step(1, 0, 16'h00A1, 16'h00A1, 3'd1, 0, 0, "rst_push1");
    step(1, 0, 16'h00A2, 16'h00A2, 3'd2, 0, 0, "rst_push2");
    step(1, 0, 16'h00A3, 16'h00A3, 3'd3, 0, 0, "rst_push3");
    push    = 1'b1;
    data_in = 16'h00AB;
    #3;
    reset = 1'b0;
    #1;
    check("async_reset", snap(), expect_of(16'h0000, 3'd0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    check("reset_held_push", snap(), expect_of(16'h0000, 3'd0, 1'b0, 1'b0));
    reset = 1'b1;
    step(1, 0, 16'h00AB, 16'h00AB, 3'd1, 0, 0, "first_edge_after_reset");
    step(0, 1, 16'h0000, 16'h0000, 3'd0, 0, 0, "pop_after_reset");

`ifdef CPU_STACK_ERR_STICKY_EN
    clear_err = 1'b0;
    step(0, 1, 16'h0000, 16'h0000, 3'd0, 0, 1, "sticky_set");
    for (int k = 0; k < 5; k++)
      step(0, 0, 16'h0000, 16'h0000, 3'd0, 0, 1, $sformatf("sticky_hold%0d", k));
    clear_err = 1'b1;
    step(0, 1, 16'h0000, 16'h0000, 3'd0, 0, 1, "sticky_set_wins");
    step(0, 0, 16'h0000, 16'h0000, 3'd0, 0, 0, "sticky_cleared");
    clear_err = 1'b0;
`endif

    push = 1'b0;
    pop  = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
